// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: FIFO-buffered stereo sample pairs shifted out MSB-first in I2S framing.
// Optional DACTX_HOLD_LAST_EN: on underflow, repeat the last popped pair instead of sending zeros.
module i2s_dac_tx #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata_left,
  input  logic [DATA_W-1:0] writedata_right,
  output logic              write_ready,
  input  logic              AUD_BCLK,
  input  logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  output logic              underflow,
  output logic [15:0]       underflow_count
);

  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(DATA_W + 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W);
  localparam logic [IDX_W-1:0] IDX_SAT  = IDX_W'(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {ST_UNARMED, ST_ARMED} arm_state_t;

  logic bclk_meta, bclk_s, bclk_prev;
  logic lrck_meta, lrck_s;
  logic bclk_fall;

  logic [DATA_W-1:0] mem_left  [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_right [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_empty;
  logic              push, pop;
  logic              left_start;

  arm_state_t        state;
  logic              lrck_prev;
  logic [DATA_W-1:0] shifter;
  logic [DATA_W-1:0] right_hold;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] fill_left, fill_right;

  // CODEC clocks are asynchronous; a third BCLK flop gives the falling-edge detect
  always_ff @(posedge ck) begin
    if (rst) begin
      bclk_meta <= 1'b0;
      bclk_s    <= 1'b0;
      bclk_prev <= 1'b0;
      lrck_meta <= 1'b0;
      lrck_s    <= 1'b0;
    end else begin
      bclk_meta <= AUD_BCLK;
      bclk_s    <= bclk_meta;
      bclk_prev <= bclk_s;
      lrck_meta <= AUD_DACLRCK;
      lrck_s    <= lrck_meta;
    end
  end

  assign bclk_fall   = bclk_prev & ~bclk_s;
  assign write_ready = (count != CNT_FULL);
  assign fifo_empty  = (count == '0);
  assign push        = write & write_ready & ~rst;
  assign left_start  = bclk_fall & (state == ST_ARMED) & (lrck_s != lrck_prev) & ~lrck_s;
  assign pop         = left_start & ~fifo_empty;

  always_ff @(posedge ck) begin
    if (push) begin
      mem_left[wr_ptr]  <= writedata_left;
      mem_right[wr_ptr] <= writedata_right;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef DACTX_HOLD_LAST_EN
  logic [DATA_W-1:0] last_left, last_right;

  always_ff @(posedge ck) begin
    if (rst) begin
      last_left  <= '0;
      last_right <= '0;
    end else if (pop) begin
      last_left  <= mem_left[rd_ptr];
      last_right <= mem_right[rd_ptr];
    end
  end

  assign fill_left  = last_left;
  assign fill_right = last_right;
`else
  assign fill_left  = '0;
  assign fill_right = '0;
`endif

  // Slot start sends the I2S one-bit-delay zero; the word then shifts out MSB-first
  always_ff @(posedge ck) begin
    if (rst) begin
      state           <= ST_UNARMED;
      lrck_prev       <= 1'b0;
      shifter         <= '0;
      right_hold      <= '0;
      bit_idx         <= IDX_SAT;
      AUD_DACDAT      <= 1'b0;
      underflow       <= 1'b0;
      underflow_count <= '0;
    end else begin
      underflow <= 1'b0;
      if (bclk_fall) begin
        lrck_prev <= lrck_s;
        case (state)
          ST_UNARMED: begin
            state <= ST_ARMED;
          end
          ST_ARMED: begin
            if (lrck_s != lrck_prev) begin
              AUD_DACDAT <= 1'b0;
              bit_idx    <= '0;
              if (!lrck_s) begin
                if (!fifo_empty) begin
                  shifter    <= mem_left[rd_ptr];
                  right_hold <= mem_right[rd_ptr];
                end else begin
                  shifter    <= fill_left;
                  right_hold <= fill_right;
                  underflow  <= 1'b1;
                  if (underflow_count != 16'hFFFF) begin
                    underflow_count <= underflow_count + 16'd1;
                  end
                end
              end else begin
                shifter <= right_hold;
              end
            end else if (bit_idx < IDX_LAST) begin
              bit_idx    <= bit_idx + IDX_W'(1);
              AUD_DACDAT <= shifter[DATA_W-1];
              shifter    <= {shifter[DATA_W-2:0], 1'b0};
            end else begin
              bit_idx    <= IDX_SAT;
              AUD_DACDAT <= 1'b0;
            end
          end
          default: state <= ST_UNARMED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: a slot-level model queues the expected bit for every BCLK fall,
// and a monitor compares AUD_DACDAT two and three ck after each pin fall.
`timescale 1ns/1ps
module tb_i2s_dac_tx;
  localparam int DATA_W     = 24;
  localparam int FIFO_DEPTH = 4;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        write = 1'b0;
  logic [23:0] writedata_left = '0;
  logic [23:0] writedata_right = '0;
  logic        write_ready;
  logic        AUD_BCLK = 1'b1;
  logic        AUD_DACLRCK = 1'b0;
  logic        AUD_DACDAT;
  logic        underflow;
  logic [15:0] underflow_count;

  i2s_dac_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .ck(ck), .rst(rst), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right),
    .write_ready(write_ready), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT(AUD_DACDAT), .underflow(underflow), .underflow_count(underflow_count)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic exp_bit;
    logic prev_bit;
    int   due;
  } sb_item_t;

  sb_item_t    sb[$];
  logic [47:0] m_fifo[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_falls = 0;
  int          falls_to_edge = 0;
  int          m_left_cyc = -1;
  int          m_pos = 25;
  int          uf_seen = 0;
  bit          lrck_run = 0;
  bit          m_active = 0;
  bit          m_armed = 0;
  logic        m_lrck_prev = 1'b0;
  logic        m_last = 1'b0;
  logic [23:0] m_word = '0;
  logic [23:0] m_rhold = '0;
  logic [47:0] m_held = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic modelReset();
    m_fifo.delete();
    sb.delete();
    m_armed = 0;
    m_pos   = 25;
    m_last  = 1'b0;
    m_word  = '0;
    m_rhold = '0;
    m_held  = '0;
    uf_seen = 0;
  endtask

  // Expected serial bit for the current BCLK fall, as the CODEC should see it
  task automatic modelFall();
    logic        e;
    logic [47:0] p;
    e = m_last;
    if (!m_armed) begin
      m_armed     = 1;
      m_lrck_prev = AUD_DACLRCK;
    end else if (AUD_DACLRCK != m_lrck_prev) begin
      m_lrck_prev = AUD_DACLRCK;
      m_pos = 0;
      e = 1'b0;
      if (!AUD_DACLRCK) begin
        m_left_cyc = cyc;
        if (m_fifo.size() > 0) begin
          p = m_fifo.pop_front();
          m_held = p;
        end else begin
`ifdef DACTX_HOLD_LAST_EN
          p = m_held;
`else
          p = '0;
`endif
        end
        m_word  = p[47:24];
        m_rhold = p[23:0];
      end else begin
        m_word = m_rhold;
      end
    end else begin
      if (m_pos < 25) m_pos++;
      e = (m_pos <= 24) ? m_word[24-m_pos] : 1'b0;
    end
    sb.push_back('{exp_bit: e, prev_bit: m_last, due: cyc + 3});
    m_last = e;
  endtask

  initial begin
    forever begin
      @(posedge ck);
      #1;
      cyc++;
      if (cyc % 8 == 0) begin
        AUD_BCLK = ~AUD_BCLK;
        if (!AUD_BCLK) begin
          n_falls++;
          if (lrck_run) begin
            falls_to_edge--;
            if (falls_to_edge <= 0) begin
              AUD_DACLRCK   = ~AUD_DACLRCK;
              falls_to_edge = 32;
            end
          end
          if (m_active) modelFall();
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge ck);
      if (underflow === 1'b1) uf_seen++;
      if (sb.size() > 0) begin
        if (cyc == sb[0].due - 1) begin
          checkOutput("dacdat_before_latency", 32'(AUD_DACDAT), 32'(sb[0].prev_bit));
        end else if (cyc == sb[0].due) begin
          checkOutput("dacdat_bit", 32'(AUD_DACDAT), 32'(sb[0].exp_bit));
          sb.delete(0);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r);
    write = 1'b1;
    writedata_left  = l;
    writedata_right = r;
    checkOutput("write_ready_at_push", 32'(write_ready), 32'(m_fifo.size() != FIFO_DEPTH));
    if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back({l, r});
    @(posedge ck);
    #2;
    write = 1'b0;
  endtask

  task automatic waitFalls(input int n);
    int target;
    int budget;
    target = n_falls + n;
    budget = n * 16 + 40;
    while (n_falls < target && budget > 0) begin
      @(posedge ck);
      #2;
      budget--;
    end
    if (n_falls < target) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_falls: got %0d falls expected %0d", n_falls, target);
    end
  endtask

  task automatic waitLeftStart();
    int marker;
    int budget;
    marker = m_left_cyc;
    budget = 70 * 16;
    while (m_left_cyc == marker && budget > 0) begin
      @(posedge ck);
      #2;
      budget--;
    end
    if (m_left_cyc == marker) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_left_start: got no left start expected one within budget");
    end
  endtask

  initial begin
    repeat (12) @(posedge ck);
    #2;
    rst = 1'b0;
    modelReset();
    m_active = 1;
    checkOutput("reset_dacdat", 32'(AUD_DACDAT), 32'd0);
    checkOutput("reset_write_ready", 32'(write_ready), 32'd1);
    checkOutput("reset_underflow", 32'(underflow), 32'd0);
    checkOutput("reset_underflow_count", 32'(underflow_count), 32'd0);
    falls_to_edge = 4;
    lrck_run = 1;

    // single pair through one full frame
    waitFalls(10);
    applyStimulus(24'hA5A5A5, 24'h3C3C3C);
    waitLeftStart();
    waitFalls(60);
    checkOutput("t1_underflow_count", 32'(underflow_count), 32'd0);
    checkOutput("t1_underflow_pulses", 32'(uf_seen), 32'd0);

    // three starved frames
    waitFalls(140);
    checkOutput("t3_underflow_count", 32'(underflow_count), 32'd3);
    checkOutput("t3_underflow_pulses", 32'(uf_seen), 32'd3);

    // fill the FIFO with LRCK halted in the right slot
    waitFalls(30);
    lrck_run = 0;
    applyStimulus(24'h123456, 24'h654321);
    applyStimulus(24'hF0F0F0, 24'h0F0F0F);
    applyStimulus(24'hC00003, 24'h300000);
    applyStimulus(24'h5A5A5A, 24'hAAAAAA);
    checkOutput("t2_full_after_4", 32'(write_ready), 32'd0);
    applyStimulus(24'hDEADBE, 24'hEFEFEF);
    checkOutput("t2_full_after_ignored", 32'(write_ready), 32'd0);
    falls_to_edge = 2;
    lrck_run = 1;
    waitLeftStart();
    waitFalls(2);
    checkOutput("t2_ready_after_pop", 32'(write_ready), 32'd1);
    applyStimulus(24'h7FFFFF, 24'h000001);
    checkOutput("t2_count3_then_full", 32'(write_ready), 32'd0);

    // push in the exact pop cycle with two entries queued
    waitLeftStart();
    waitLeftStart();
    waitLeftStart();
    repeat (2) begin
      @(posedge ck);
      #2;
    end
    applyStimulus(24'h0000FF, 24'hFF0000);
    waitFalls(2);
    applyStimulus(24'h111111, 24'h222222);
    checkOutput("t4_ready_count3", 32'(write_ready), 32'd1);
    applyStimulus(24'h333333, 24'h444444);
    checkOutput("t4_full_count4", 32'(write_ready), 32'd0);

    // reset in the middle of a left word
    waitLeftStart();
    waitFalls(10);
    repeat (5) begin
      @(posedge ck);
      #2;
    end
    rst = 1'b1;
    modelReset();
    @(posedge ck);
    #2;
    rst = 1'b0;
    checkOutput("t5_dacdat_after_reset", 32'(AUD_DACDAT), 32'd0);
    checkOutput("t5_write_ready_after_reset", 32'(write_ready), 32'd1);
    checkOutput("t5_underflow_count_after_reset", 32'(underflow_count), 32'd0);
    waitLeftStart();
    waitFalls(5);
    applyStimulus(24'h800001, 24'h123456);
    waitLeftStart();
    waitFalls(60);
    checkOutput("t5_underflow_count_recovered", 32'(underflow_count), 32'd1);
    checkOutput("t5_underflow_pulses_recovered", 32'(uf_seen), 32'd1);
    repeat (5) @(posedge ck);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

Serial transmit end of the audio path: accepts parallel left/right sample pairs from the filter datapath via a write/write_ready handshake, buffers them in a small FIFO, and shifts them out MSB-first in I2S format on AUD_DACDAT. The CODEC is bit-clock and frame-clock master. AUD_BCLK and AUD_DACLRCK are sampled in the ck domain. The block sits between the per-channel fir outputs and the AUD_* pins.

## Interface
- DATA_W, 24, sample width per channel (≤ 31 BCLK slots per half-frame required)
- FIFO_DEPTH, 4, sample-pair entries; power of two, ≥ 2
- ck  in  1  system clock (CLOCK_50); one clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- write  in  1  push request for one sample pair
- writedata_left  in  DATA_W  left sample, two's complement
- writedata_right  in  DATA_W  right sample, two's complement
- write_ready  out  1  FIFO not full; pair accepted on cycle where write && write_ready
- AUD_BCLK  in  1  CODEC bit clock, asynchronous to ck
- AUD_DACLRCK  in  1  CODEC frame clock; 0 = left slot, 1 = right slot
- AUD_DACDAT  out  1  serial data to CODEC
- underflow  out  1  one-ck pulse: left slot started with FIFO empty
- underflow_count  out  16  saturating count of underflow events

## Operation
- Sync: AUD_BCLK and AUD_DACLRCK each pass through a 2-flop synchronizer. bclk_fall is asserted when the synchronized BCLK was 1 on the previous cycle and is 0 now. All serial actions occur only on ck cycles with bclk_fall.
- Arming: the first bclk_fall after reset only captures lrck_prev; no data action. armed is set.
- Slot start: on an armed bclk_fall with lrck_s != lrck_prev, drive AUD_DACDAT=0, reset bit_idx to 0, and load the shift register:
  - lrck_s=0 (left start): pop the FIFO if it is non-empty. Load left into the shifter; hold right in the right_hold register.
  - lrck_s=1 (right start): load right_hold.
- Bits: on subsequent bclk_falls, bit_idx 1..DATA_W drive shifter MSB-first (bit DATA_W−bit_idx). For bit_idx > DATA_W, drive 0 and saturate bit_idx.
- Underflow: a left start with the FIFO empty asserts underflow for 1 ck and increments underflow_count, saturating at 16'hFFFF. Zeros are loaded for both channels (see Configuration).
- FIFO: count range 0..FIFO_DEPTH. write_ready = (count != FIFO_DEPTH), combinational. Push and pop on the same cycle: both occur and count is unchanged. A write while full is ignored.
- Reset (any time, including mid-word):
  - FIFO emptied; write_ready=1; AUD_DACDAT=0; underflow=0; underflow_count=0.
  - armed=0; shifter=0; right_hold=0; bit_idx saturated (idle zeros).
  - write is ignored while rst=1.

## Timing
- AUD_BCLK pin falling edge → AUD_DACDAT update: 3 ck cycles (2 sync + 1 output register). AUD_DACDAT is registered.
- AUD_BCLK high and low phases must each be ≥ 3 ck periods. At 50 MHz ck and 3.072 MHz BCLK there is ample margin.
- I2S one-bit delay: the MSB appears on the second BCLK falling edge after the LRCK transition.
- Push → earliest serialization: the next left start after the push.
- Pop is a single ck cycle, coinciding with the left-start bclk_fall.
- A simultaneous push in the pop cycle on a full FIFO is not possible, because write_ready=0. A push on the pop cycle when count < FIFO_DEPTH is accepted.

## Configuration
- DACTX_HOLD_LAST_EN defined: on underflow, the shifter and right_hold reload the last successfully popped pair, which repeats the sample. The pair is 0 if nothing has been popped since reset. The underflow pulse and count are unchanged.
- Not defined: on underflow, both channels transmit zeros.

## Test plan
Bench: BCLK period 16 ck; LRCK toggles every 32 BCLK falling edges; DATA_W=24.

1. Reset then push (L=24'hA5A5A5, R=24'h3C3C3C). Required: after the next left start, AUD_DACDAT carries 1010…0101 in BCLK slots 1..24 and zeros in slots 25..31; the right slot carries 0011_1100 repeated. underflow stays 0.
2. Push 4 pairs back-to-back with no LRCK. Required: write_ready drops the cycle after the 4th push, and a 5th write while full is ignored. After one left start, write_ready=1 and count=3.
3. No pushes for 3 frames after arming. Required: 3 underflow pulses, underflow_count=3, AUD_DACDAT constantly 0 (macro off). With DACTX_HOLD_LAST_EN and a prior pair L=24'h800001, the left slot repeats 1000…0001 in each frame.
4. Assert write in the exact ck of a left-start pop with count=2. Required: count stays 2 and the popped pair is the oldest pair.
5. Assert rst for 1 ck at BCLK slot 10 of a left word. Required: AUD_DACDAT=0 from the next cycle; write_ready=1; underflow_count=0; nothing transmitted until after arming and the next LRCK edge.
6. Measure AUD_BCLK pin fall → AUD_DACDAT change. Required: exactly 3 ck, for every bit.
